ifetch_stage: RTL and testbench

//  Instruction-fetch stage between the PC register and decode. Issues the

---
 rtl/ifetch_stage.sv | 218 +++++++++++++++++++++
 tb/tb_ifetch_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage
// Purpose  : Instruction-fetch stage between the PC register and decode.
//            Issues the PC to the instruction ROM over a req/gnt bus, pairs
//            in-order rvalid responses with their PCs and buffers them in a
//            small FIFO that feeds decode over valid/ready. A flush (jump)
//            empties the FIFO and discards every fetch still in flight.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_stage #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    // PC register side
    input  logic [31:0] pc_addr_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    // Control
    input  logic        flush_i,
    // Instruction ROM bus
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    // Decode side
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    // Counters must be able to hold the value FIFO_DEPTH itself.
    localparam int unsigned        c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned        c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);

    // Circular pointer increment that also works for non power-of-two depths.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Low during reset and for one clock after release, so that requests
    // only start once reset has been removed synchronously.
    logic                 r_run;

    // Address queue: PCs of requests granted but not yet answered.
    logic [31:0]          r_aq_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_aq_wptr;
    logic [c_PTR_W-1:0]   r_aq_rptr;
    logic [c_CNT_W-1:0]   r_outstanding;
    // Number of in-flight responses that belong to killed fetches.
    logic [c_CNT_W-1:0]   r_discard;

    // Output FIFO of {instruction, pc}.
    logic [31:0]          r_fifo_inst [FIFO_DEPTH];
    logic [31:0]          r_fifo_pc   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_fifo_wptr;
    logic [c_PTR_W-1:0]   r_fifo_rptr;
    logic [c_CNT_W-1:0]   r_fifo_count;
    // PC shown to decode while the FIFO is empty.
    logic [31:0]          r_last_addr;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_CNT_W:0]     w_used;
    logic                 w_credit;
    logic                 w_handshake;
    logic                 w_rsp;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_nonempty;
    logic [31:0]          w_head_pc;
    logic [31:0]          w_rsp_pc;

    // A request is only made when the FIFO is guaranteed to have room for
    // its response, so rvalid never needs back-pressure.
    assign w_used          = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign w_credit        = (w_used < c_DEPTH);

    assign rom_req_o       = r_run & pc_valid_i & ~flush_i & w_credit;
    assign rom_addr_o      = {pc_addr_i[31:2], 2'b00};
    assign w_handshake     = rom_req_o & rom_gnt_i;
    assign pc_ready_o      = w_handshake;

    // A response with nothing outstanding is a protocol error and ignored.
    assign w_rsp           = rom_rvalid_i & (r_outstanding != '0);
    assign w_rsp_pc        = r_aq_mem[r_aq_rptr];
    // Responses of killed fetches, and any response in a flush cycle, are dropped.
    assign w_push          = w_rsp & (r_discard == '0) & ~flush_i;

    assign w_fifo_nonempty = (r_fifo_count != '0);
    assign w_head_pc       = r_fifo_pc[r_fifo_rptr];
    // A pop that coincides with a flush has no effect.
    assign w_pop           = w_fifo_nonempty & inst_ready_i & ~flush_i;

    assign inst_valid_o    = w_fifo_nonempty;
    assign inst_o          = w_fifo_nonempty ? r_fifo_inst[r_fifo_rptr] : NOP_INST;
    assign inst_addr_o     = w_fifo_nonempty ? w_head_pc : r_last_addr;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // Run enable: cleared asynchronously, set on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Address queue pointers and outstanding-request counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aq_wptr     <= '0;
            r_aq_rptr     <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_handshake) begin
                r_aq_wptr <= ptr_inc(r_aq_wptr);
            end
            // Entries are kept across a flush so later responses still pair up.
            if (w_rsp) begin
                r_aq_rptr <= ptr_inc(r_aq_rptr);
            end
            case ({w_handshake, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Address queue storage; no reset needed, entries are qualified by pointers.
    always_ff @(posedge clk) begin
        if (w_handshake) begin
            r_aq_mem[r_aq_wptr] <= pc_addr_i;
        end
    end

    // Discard counter: on flush every still-pending response becomes stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_discard <= '0;
        end else if (flush_i) begin
            // A response arriving in the flush cycle is dropped right now.
            r_discard <= r_outstanding - c_CNT_W'(w_rsp);
        end else if (w_rsp && (r_discard != '0)) begin
            r_discard <= r_discard - 1'b1;
        end
    end

    // Output FIFO pointers and occupancy; flush empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_wptr  <= '0;
            r_fifo_rptr  <= '0;
            r_fifo_count <= '0;
        end else if (flush_i) begin
            r_fifo_wptr  <= '0;
            r_fifo_rptr  <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wptr <= ptr_inc(r_fifo_wptr);
            end
            if (w_pop) begin
                r_fifo_rptr <= ptr_inc(r_fifo_rptr);
            end
            r_fifo_count <= r_fifo_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Output FIFO storage; written only with a live response.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_fifo_wptr] <= rom_rdata_i;
            r_fifo_pc[r_fifo_wptr]   <= w_rsp_pc;
        end
    end

    // Remember the most recently presented PC for display while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= '0;
        end else if (w_fifo_nonempty) begin
            r_last_addr <= w_head_pc;
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks (simulation only; ignored by synthesis)
    // ------------------------------------------------------------------
    // The ROM must not answer unless a request is in flight.
    a_rvalid_has_outstanding : assert property (
        @(posedge clk) disable iff (!rst_n)
        rom_rvalid_i |-> (r_outstanding != '0));

    // The credit rule must make a push into a full FIFO without a pop impossible.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        (w_push && !w_pop) |-> (r_fifo_count != c_FULL));

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_stage
// Purpose  : Self-checking bench for ifetch_stage. A ROM model answers
//            granted requests in order; directed tests queue the PCs that
//            must reach decode and a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_stage;

    localparam int unsigned c_DEPTH = 2;
    localparam logic [31:0] c_NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc_addr_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] exp_q    [$];
    logic [31:0] rom_pend [$];
    logic        rom_hold = 1'b0;
    int          hs_count = 0;
    int          hs0;
    logic [31:0] pc_stop;
    logic [31:0] mon_exp;
    logic        found;

    ifetch_stage #(
        .FIFO_DEPTH (c_DEPTH),
        .NOP_INST   (c_NOP)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_addr_i    (pc_addr_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    // ROM contents: a fixed function of the word address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, 16'hBEEF};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ROM model: records handshakes mid-cycle, answers one cycle later in order.
    initial begin
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rom_pend.delete();
            end else if (rom_req_o && rom_gnt_i) begin
                rom_pend.push_back(rom_addr_o);
                hs_count++;
            end
            @(posedge clk);
            #1;
            if (rst_n && !rom_hold && rom_pend.size() > 0) begin
                rom_rvalid_i = 1'b1;
                rom_rdata_i  = rom_word(rom_pend.pop_front());
            end else begin
                rom_rvalid_i = 1'b0;
                rom_rdata_i  = 32'hDEADDEAD;
            end
        end
    end

    // Monitor: every accepted instruction must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && !flush_i && inst_valid_o && inst_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_addr=%h actual_inst=%h expected=none",
                         inst_addr_o, inst_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_addr", inst_addr_o, mon_exp);
                check("out_inst", inst_o, rom_word({mon_exp[31:2], 2'b00}));
            end
        end
    end

    // One clock of the PC register model: advance on an accepted request.
    task automatic cycle();
        logic adv;
        @(negedge clk);
        adv = pc_ready_o;
        @(posedge clk);
        #2;
        if (adv) pc_addr_i = pc_addr_i + 32'd4;
        pc_valid_i = (pc_addr_i != pc_stop);
    endtask

    task automatic set_pc(input logic [31:0] a, input logic [31:0] stop);
        pc_addr_i  = a;
        pc_stop    = stop;
        pc_valid_i = (a != stop);
        hs0        = hs_count;
    endtask

    // Wait (bounded) until every expected instruction has been seen.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        repeat (4) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual_remaining=%0d expected=0", name, exp_q.size());
        end
        check({name, "_pc_end"}, pc_addr_i, pc_stop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        pc_addr_i    = 32'h0;
        pc_valid_i   = 1'b1;
        pc_stop      = 32'hFFFF_FFFF;
        flush_i      = 1'b0;
        rom_gnt_i    = 1'b1;
        inst_ready_i = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        // Reset state with a request pending on the PC side
        check("rst_inst_valid", inst_valid_o, 1'b0);
        check("rst_inst",       inst_o,       c_NOP);
        check("rst_inst_addr",  inst_addr_o,  32'h0);
        check("rst_rom_req",    rom_req_o,    1'b0);
        check("rst_pc_ready",   pc_ready_o,   1'b0);

        // 1: streaming fetch
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        set_pc(32'h0, 32'h10);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_drain("stream");

        // 2: decode back-pressure caps requests at the FIFO depth
        inst_ready_i = 1'b0;
        exp_q = '{32'h400, 32'h404, 32'h408, 32'h40C};
        set_pc(32'h400, 32'h410);
        repeat (6) cycle();
        check("bp_req_blocked", rom_req_o,    1'b0);
        check("bp_pc_held",     pc_addr_i,    32'h408);
        check("bp_valid",       inst_valid_o, 1'b1);
        check("bp_head_addr",   inst_addr_o,  32'h400);
        check("bp_head_inst",   inst_o,       rom_word(32'h400));
        check("bp_handshakes",  32'(hs_count - hs0), 32'd2);
        inst_ready_i = 1'b1;
        wait_drain("backpressure");

        // 3: grant stall with an unaligned PC; flush masks the request combinationally
        rom_gnt_i = 1'b0;
        exp_q = '{32'h502};
        set_pc(32'h502, 32'h506);
        flush_i = 1'b1;
        #1;
        check("flush_masks_req", rom_req_o, 1'b0);
        flush_i = 1'b0;
        #1;
        check("unflush_req", rom_req_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("stall_req",      rom_req_o,  1'b1);
            check("stall_pc_ready", pc_ready_o, 1'b0);
            check("stall_rom_addr", rom_addr_o, 32'h500);
            cycle();
        end
        rom_gnt_i = 1'b1;
        wait_drain("gnt_stall");
        check("stall_handshakes", 32'(hs_count - hs0), 32'd1);

        // 4: flush with two fetches in flight
        rom_hold = 1'b1;
        set_pc(32'h0, 32'h10);
        repeat (4) cycle();
        check("fl_inflight",    32'(hs_count - hs0), 32'd2);
        check("fl_req_blocked", rom_req_o,  1'b0);
        check("fl_pc_at_8",     pc_addr_i,  32'h8);
        flush_i    = 1'b1;
        pc_addr_i  = 32'h100;
        pc_stop    = 32'h10C;
        pc_valid_i = 1'b1;
        exp_q = '{32'h100, 32'h104, 32'h108};
        cycle();
        flush_i  = 1'b0;
        rom_hold = 1'b0;
        check("fl_valid_after", inst_valid_o, 1'b0);
        wait_drain("flush_inflight");

        // 5: flush in the same cycle as a response and a pop
        set_pc(32'h200, 32'h240);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            cycle();
            if (inst_valid_o && rom_rvalid_i) found = 1'b1;
        end
        check("co_found", found, 1'b1);
        flush_i    = 1'b1;
        pc_addr_i  = 32'h300;
        pc_stop    = 32'h308;
        pc_valid_i = 1'b1;
        exp_q = '{32'h300, 32'h304};
        cycle();
        flush_i = 1'b0;
        check("co_valid_after", inst_valid_o, 1'b0);
        check("co_inst_after",  inst_o,       c_NOP);
        wait_drain("flush_coincident");

        // 6: reset in the middle of a stream
        exp_q = '{32'h700, 32'h704, 32'h708, 32'h70C};
        set_pc(32'h700, 32'h710);
        repeat (5) cycle();
        check("rst_pre_valid", inst_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",     inst_valid_o, 1'b0);
        check("mid_rst_inst",      inst_o,       c_NOP);
        check("mid_rst_inst_addr", inst_addr_o,  32'h0);
        check("mid_rst_rom_req",   rom_req_o,    1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q = '{32'h0, 32'h4};
        set_pc(32'h0, 32'h8);
        wait_drain("reset_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
